// File: rtl/seq_logic_unit.sv
// Slice-serial bitwise logic unit.
//
// Captures two operands and an opcode on start, then evaluates the selected bitwise
// function (AND/OR/XOR/NOR) one SLICE-bit slice per clock, LSB slice first. After
// N = WIDTH/SLICE slice steps the assembled word is published on result_o, zero_o is
// refreshed and done_o pulses for one cycle.
//
// Ports:
//   clk_i     clock, all state on rising edge
//   rst_i     synchronous active-high reset
//   start_i   operation request, sampled only while idle
//   op_i      00 AND, 01 OR, 10 XOR, 11 NOR
//   a_i, b_i  operands, captured with start_i
//   busy_o    high while an operation is in progress
//   done_o    one-cycle pulse, result_o valid
//   result_o  last completed result
//   zero_o    high when the last completed result is all zeros
//
// WIDTH must be an integer multiple of SLICE.
module seq_logic_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  localparam int unsigned N    = WIDTH / SLICE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  localparam logic StIdle = 1'b0;
  localparam logic StRun  = 1'b1;

  localparam logic [1:0] OpAnd = 2'b00;
  localparam logic [1:0] OpOr  = 2'b01;
  localparam logic [1:0] OpXor = 2'b10;
  localparam logic [1:0] OpNor = 2'b11;

  logic             state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] func_w;
  logic [WIDTH-1:0] acc_next;

  // Full-width function of the captured operands; only the current slice is taken from it.
  always_comb begin
    func_w = '0;
    unique case (op_q)
      OpAnd:   func_w = a_q & b_q;
      OpOr:    func_w = a_q | b_q;
      OpXor:   func_w = a_q ^ b_q;
      OpNor:   func_w = ~(a_q | b_q);
      default: func_w = '0;
    endcase
  end

  // Merge the slice addressed by the counter into the partial accumulator.
  always_comb begin
    acc_next = acc_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt_q == CntW'(i)) begin
        acc_next[i*SLICE +: SLICE] = func_w[i*SLICE +: SLICE];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          op_d    = op_i;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = acc_next;
        if (cnt_q == CntW'(N - 1)) begin
          // Last slice: publish the assembled word in the same edge.
          result_d = acc_next;
          zero_d   = (acc_next == '0);
          done_d   = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = (state_q == StRun);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;

endmodule

// File: doc/seq_logic_unit.md
SEQ_LOGIC_UNIT -- requirements
Module: seq_logic_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width in bits.
REQ-002 Parameter SLICE, default 8, SHALL set the number of bits processed per cycle; WIDTH SHALL be an integer multiple of SLICE, and N = WIDTH/SLICE.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 start  input  1  SHALL request an operation; it is sampled only when busy=0.
REQ-006 op  input  2  SHALL select the operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-007 a  input  WIDTH  SHALL be operand A, captured with start.
REQ-008 b  input  WIDTH  SHALL be operand B, captured with start.
REQ-009 busy  output  1  SHALL be high while an operation is in progress.
REQ-010 done  output  1  SHALL be a one-cycle pulse marking result valid.
REQ-011 result  output  WIDTH  SHALL hold the last completed result.
REQ-012 zero  output  1  SHALL be high when the last completed result is all zeros.

Function
REQ-013 The unit SHALL have two states: IDLE (busy=0) and RUN (busy=1).
REQ-014 In IDLE, start=1 at edge k SHALL capture a, b and op into internal registers, clear the slice counter, and enter RUN.
REQ-015 In RUN, each edge SHALL compute one SLICE-bit slice of the captured operands, LSB slice first, and increment the slice counter.
REQ-016 Slice i SHALL be computed at edge k+1+i, for i = 0..N-1.
REQ-017 At edge k+N the full result SHALL be copied to result, zero SHALL be updated, done SHALL go high for exactly one cycle, and the state SHALL return to IDLE.
REQ-018 Latency SHALL be N cycles from the start sample to done high; for the defaults this is 4.
REQ-019 result and zero SHALL hold their previous values during RUN; partial slices SHALL never be visible on result.
REQ-020 start while busy=1 SHALL be ignored, and the captured operands SHALL remain unchanged.
REQ-021 start=1 in the cycle done=1 (busy=0) SHALL be accepted, giving back-to-back operations every N+1 cycles.
REQ-022 Changes on a, b or op after capture SHALL NOT affect the operation in progress.
REQ-023 For N=1 (SLICE=WIDTH) the unit SHALL complete in one cycle with the same handshake.
REQ-024 Slice counter width SHALL be ceil(log2(N)) bits, minimum 1; the counter SHALL NOT wrap during an operation.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, with busy=0, done=0, result=0, zero=1, and the slice counter and captured registers cleared.
REQ-026 rst SHALL take priority over start and abort any operation in RUN mid-way; no done pulse SHALL follow.
REQ-027 After rst is released, the first start SHALL behave exactly per REQ-014 to REQ-018.

Verification (WIDTH=32, SLICE=8)
REQ-028 OR test: a=0x0F0F0000, b=0x00F000FF, op=01, start pulse -> done exactly 4 cycles later, result=0x0FFF00FF, zero=0.
REQ-029 NOR and zero flag:
- First, a=0xFFFFFFFF, b=0, op=11 -> result=0x00000000, zero=1.
- Then XOR with a=b=0x12345678 -> result=0, zero=1.
REQ-030 Busy ignore: start again at cycle 2 of RUN with a=0xFFFFFFFF, op=00 -> ignored; the original AND of 0xFFFF0000 and 0x00FFFF00 completes with 0x00FF0000, and there is a single done pulse.
REQ-031 Back-to-back:
- Assert start during the done cycle with new operands.
- Required: second done exactly 5 cycles after the first.
- Required: result is unchanged between the two done pulses.
REQ-032 Reset mid-op: assert rst at cycle 2 of RUN -> next cycle busy=0, done=0, result=0, zero=1, and no done pulse follows.
REQ-033 Operand hold: change a and b every cycle during RUN -> result SHALL match the operands captured at start.
